// File: rtl/daccess_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : daccess_mem_responder_pkg                                     |
// | Purpose  : Shared types and constants for the daccess memory responder:  |
// |            FSM state encoding, latency counter width, request decode.    |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package daccess_mem_responder_pkg;

  // Wide enough for the full latency range 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_WAIT = 2'd1,
    DR_RESP = 2'd2
  } dr_state_t;

  // Any nonzero read strobe or byte enable constitutes a request.
  function automatic logic is_req(input logic [3:0] ren, input logic [3:0] wen);
    return (ren != 4'h0) || (wen != 4'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/daccess_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : daccess_mem_responder_if                                      |
// | Purpose  : CPU data-access bus between the pipeline (master) and the     |
// |            memory responder (slave).                                     |
// | Ports    : master drives daccess_ren/addr/wen/wdata;                     |
// |            slave drives daccess_valid/rdata/wresp, busy, proto_err.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface daccess_mem_responder_if;
  logic [3:0]  daccess_ren;
  logic [31:0] daccess_addr;
  logic [3:0]  daccess_wen;
  logic [31:0] daccess_wdata;
  logic        daccess_valid;
  logic [31:0] daccess_rdata;
  logic        daccess_wresp;
  logic        busy;
  logic        proto_err;

  modport master (
    output daccess_ren, daccess_addr, daccess_wen, daccess_wdata,
    input  daccess_valid, daccess_rdata, daccess_wresp, busy, proto_err
  );

  modport slave (
    input  daccess_ren, daccess_addr, daccess_wen, daccess_wdata,
    output daccess_valid, daccess_rdata, daccess_wresp, busy, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/daccess_mem_responder_bram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : daccess_bram                                                  |
// | Purpose  : 2**ADDR_W x 32 single-port RAM with four byte-lane write      |
// |            enables and a synchronous, enable-gated read port.            |
// | Ports    : cpu_clk  - clock                                              |
// |            we[3:0]  - byte-lane write enables                            |
// |            addr     - word address (shared by read and write)            |
// |            wdata    - lane-aligned write data                            |
// |            re       - read enable; rdata updates only when set           |
// |            rdata    - registered read data                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module daccess_bram #(
  parameter int ADDR_W = 10
) (
  input  wire logic              cpu_clk,
  input  wire logic [3:0]        we,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [31:0]       wdata,
  input  wire logic              re,
  output logic      [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  // Contents are deliberately not reset so they survive a CPU reset.
  always_ff @(posedge cpu_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/daccess_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : daccess_mem_responder                                         |
// | Purpose  : Memory-side responder for the CPU daccess bus. Serves one     |
// |            load or store at a time after LATENCY cycles, answering with  |
// |            a one-cycle daccess_valid (load) or daccess_wresp (store).    |
// | Ports    : cpu_clk  - clock                                              |
// |            cpu_rstn - asynchronous active-low reset                      |
// |            bus      - daccess slave modport (request in, response out,   |
// |                       busy and sticky proto_err flags)                   |
// | Params   : ADDR_W (word-address width), LATENCY (1..15),                 |
// |            BASE (byte base address of the array)                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module daccess_mem_responder
  import daccess_mem_responder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0
) (
  input wire logic               cpu_clk,
  input wire logic               cpu_rstn,
  daccess_mem_responder_if.slave bus
);

  localparam logic [32:0]      c_limit    = {1'b0, BASE} + (33'd4 << ADDR_W);
  localparam bit               c_lat1     = (LATENCY == 1);
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LATENCY - 1);

  dr_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_armed;
  logic [ADDR_W-1:0]  r_word;
  logic               r_is_store;
  logic               r_in_range;
  logic [3:0]         r_wen;
  logic [31:0]        r_wdata;
  logic               r_valid;
  logic               r_wresp;
  logic [31:0]        r_rdata;
  logic               r_busy;
  logic               r_proto_err;

  logic [31:0]        w_off;
  logic [ADDR_W-1:0]  w_word_in;
  logic               w_in_range_in;
  logic               w_store_in;
  logic               w_req;
  logic               w_take;
  logic               w_to_resp;
  logic               w_cur_idle;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [3:0]         w_mem_we;
  logic [31:0]        w_mem_wdata;
  logic               w_mem_re;
  logic [31:0]        w_mem_q;
  logic               w_unused;

  // Address decode of the incoming request; bits [1:0] are dropped.
  assign w_off         = bus.daccess_addr - BASE;
  assign w_word_in     = w_off[ADDR_W+1:2];
  assign w_in_range_in = ({1'b0, bus.daccess_addr} >= {1'b0, BASE}) &&
                         ({1'b0, bus.daccess_addr} <  c_limit);
  assign w_unused      = ^{w_off[31:ADDR_W+2], w_off[1:0]};

  // A store wins over a simultaneous load.
  assign w_store_in = (bus.daccess_wen != 4'h0);
  assign w_req      = is_req(bus.daccess_ren, bus.daccess_wen);
  assign w_take     = (r_state == DR_IDLE) && r_armed && w_req;

  // The array is accessed on the edge entering RESP, so the read data is
  // ready to be registered onto the bus on the edge leaving RESP. With a
  // latency of one that edge is the accept edge itself, so the request
  // fields come straight from the bus instead of the latched copy.
  assign w_to_resp  = (w_take && c_lat1) ||
                      ((r_state == DR_WAIT) && (r_cnt == CNT_W'(1)));
  assign w_cur_idle = (r_state == DR_IDLE);

  always_comb begin
    w_mem_addr  = r_word;
    w_mem_wdata = r_wdata;
    w_mem_we    = 4'h0;
    w_mem_re    = 1'b0;
    if (w_cur_idle) begin
      w_mem_addr  = w_word_in;
      w_mem_wdata = bus.daccess_wdata;
      if (w_to_resp && w_in_range_in) begin
        if (w_store_in) w_mem_we = bus.daccess_wen;
        else            w_mem_re = 1'b1;
      end
    end else if (w_to_resp && r_in_range) begin
      if (r_is_store) w_mem_we = r_wen;
      else            w_mem_re = 1'b1;
    end
    // Keep the array untouched while reset is held, even if the bus is busy.
    if (!cpu_rstn) w_mem_we = 4'h0;
  end

  daccess_bram #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .cpu_clk (cpu_clk),
    .we      (w_mem_we),
    .addr    (w_mem_addr),
    .wdata   (w_mem_wdata),
    .re      (w_mem_re),
    .rdata   (w_mem_q)
  );

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state     <= DR_IDLE;
      r_cnt       <= '0;
      r_armed     <= 1'b1;
      r_word      <= '0;
      r_is_store  <= 1'b0;
      r_in_range  <= 1'b0;
      r_wen       <= 4'h0;
      r_wdata     <= 32'h0;
      r_valid     <= 1'b0;
      r_wresp     <= 1'b0;
      r_rdata     <= 32'h0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wresp <= 1'b0;
      // Re-arm on any idle-bus edge; the RESP branch overrides this so a
      // request still held during the response edge is not served again.
      if (!w_req) r_armed <= 1'b1;

      case (r_state)
        DR_IDLE: begin
          r_busy <= w_take;
          if (w_take) begin
            r_word     <= w_word_in;
            r_is_store <= w_store_in;
            r_in_range <= w_in_range_in;
            r_wen      <= bus.daccess_wen;
            r_wdata    <= bus.daccess_wdata;
            if ((bus.daccess_ren != 4'h0) && (bus.daccess_wen != 4'h0))
              r_proto_err <= 1'b1;
            if (c_lat1) begin
              r_state <= DR_RESP;
            end else begin
              r_state <= DR_WAIT;
              r_cnt   <= c_cnt_init;
            end
          end
        end
        DR_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= DR_RESP;
        end
        DR_RESP: begin
          // busy stays high through the following response cycle.
          r_state <= DR_IDLE;
          r_armed <= !w_req;
          if (r_is_store) begin
            r_wresp <= 1'b1;
          end else begin
            r_valid <= 1'b1;
            r_rdata <= r_in_range ? w_mem_q : 32'h0;
          end
        end
        default: r_state <= DR_IDLE;
      endcase
    end
  end

  assign bus.daccess_valid = r_valid;
  assign bus.daccess_wresp = r_wresp;
  assign bus.daccess_rdata = r_rdata;
  assign bus.busy          = r_busy;
  assign bus.proto_err     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_daccess_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_daccess_mem_responder                                      |
// | Purpose  : Self-checking bench for daccess_mem_responder. Expected       |
// |            responses are queued when a request is driven and compared    |
// |            when the responder pulses valid or wresp.                     |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_daccess_mem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic cpu_clk  = 1'b0;
  logic cpu_rstn = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  daccess_mem_responder_if bus ();

  daccess_mem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY),
    .BASE    (32'h0)
  ) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ren, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.daccess_ren   = ren;
    bus.daccess_wen   = wen;
    bus.daccess_addr  = addr;
    bus.daccess_wdata = wdata;
  endtask

  task automatic idle();
    drive(4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  // Called at a negedge where valid or wresp is high.
  task automatic score(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, " unexpected"}, {30'd0, bus.daccess_valid, bus.daccess_wresp}, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, " kind"}, {30'd0, bus.daccess_valid, bus.daccess_wresp},
              {30'd0, e.is_load, ~e.is_load});
    if (e.is_load) check_val({tag, " rdata"}, bus.daccess_rdata, e.data);
  endtask

  task automatic xact(input string tag, input logic [3:0] ren, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit exp_load, input logic [31:0] exp_data);
    int lat;
    bit seen;
    @(negedge cpu_clk);
    drive(ren, wen, addr, wdata);
    exp_q.push_back('{exp_load, exp_data});
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge cpu_clk);
      if (bus.daccess_valid || bus.daccess_wresp) begin
        seen = 1'b1;
        lat  = i;
        check_val({tag, " busy@resp"}, 32'(bus.busy), 32'd1);
        score(tag);
      end else if (i == 1) begin
        check_val({tag, " busy@wait"}, 32'(bus.busy), 32'd1);
      end
    end
    if (!seen) begin
      check_val({tag, " timeout"}, 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      // Sampled at negedges: accept edge, then LATENCY more edges.
      check_val({tag, " latency"}, 32'(lat), 32'(LATENCY + 1));
    end
    idle();
    @(negedge cpu_clk);
    check_val({tag, " no repeat"}, {30'd0, bus.daccess_valid, bus.daccess_wresp}, 32'd0);
    check_val({tag, " busy clear"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, " valid"},     32'(bus.daccess_valid), 32'd0);
    check_val({tag, " wresp"},     32'(bus.daccess_wresp), 32'd0);
    check_val({tag, " rdata"},     bus.daccess_rdata,      32'd0);
    check_val({tag, " busy"},      32'(bus.busy),          32'd0);
    check_val({tag, " proto_err"}, 32'(bus.proto_err),     32'd0);
  endtask

  initial begin
    int pulses;
    idle();
    repeat (3) @(negedge cpu_clk);
    check_quiet("reset");
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);

    // Full-word store then load back.
    xact("t1 st",  4'h0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    xact("t1 ld",  4'hF, 4'h0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF);

    // Partial-lane store merges into existing word; rdata holds afterwards.
    xact("t2 pre", 4'h0, 4'hF,    32'h20, 32'h11223344, 1'b0, 32'h0);
    xact("t2 st",  4'h0, 4'b0100, 32'h20, 32'h00AA0000, 1'b0, 32'h0);
    xact("t2 ld",  4'hF, 4'h0,    32'h20, 32'h0,        1'b1, 32'h11AA3344);
    repeat (3) @(negedge cpu_clk);
    check_val("t2 rdata hold", bus.daccess_rdata, 32'h11AA3344);

    // Load held high for 10 cycles: served once, then again after re-arm.
    xact("t3 pre", 4'h0, 4'hF, 32'h4, 32'h0BADF00D, 1'b0, 32'h0);
    @(negedge cpu_clk);
    drive(4'hF, 4'h0, 32'h4, 32'h0);
    exp_q.push_back('{1'b1, 32'h0BADF00D});
    pulses = 0;
    repeat (10) begin
      @(negedge cpu_clk);
      if (bus.daccess_valid || bus.daccess_wresp) begin
        pulses++;
        score("t3 hold");
      end
    end
    check_val("t3 pulses", 32'(pulses), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    idle();
    xact("t3 rearm", 4'hF, 4'h0, 32'h4, 32'h0, 1'b1, 32'h0BADF00D);

    // Simultaneous load and store: store wins, proto_err sticks.
    xact("t4 pre", 4'h0, 4'hF, 32'h8, 32'h12345678, 1'b0, 32'h0);
    check_val("t4 perr before", 32'(bus.proto_err), 32'd0);
    xact("t4 both", 4'hF, 4'h3, 32'h8, 32'h0000CAFE, 1'b0, 32'h0);
    check_val("t4 perr set", 32'(bus.proto_err), 32'd1);
    xact("t4 ld", 4'hF, 4'h0, 32'h8, 32'h0, 1'b1, 32'h1234CAFE);
    check_val("t4 perr sticky", 32'(bus.proto_err), 32'd1);

    // Out-of-range accesses, including the first byte past the array.
    xact("t5 pre",   4'h0, 4'hF, 32'h0,    32'hA5A5A5A5, 1'b0, 32'h0);
    xact("t5 ld oor",4'hF, 4'h0, 32'h4000, 32'h0,        1'b1, 32'h0);
    xact("t5 st oor",4'h0, 4'hF, 32'h4000, 32'hFFFFFFFF, 1'b0, 32'h0);
    xact("t5 st lim",4'h0, 4'hF, 32'h1000, 32'h77777777, 1'b0, 32'h0);
    xact("t5 ld lim",4'hF, 4'h0, 32'h1000, 32'h0,        1'b1, 32'h0);
    xact("t5 ld w0", 4'hF, 4'h0, 32'h0,    32'h0,        1'b1, 32'hA5A5A5A5);
    xact("t5 st top",4'h0, 4'hF, 32'hFFC,  32'hC0FFEE11, 1'b0, 32'h0);
    xact("t5 ld top",4'hF, 4'h0, 32'hFFF,  32'h0,        1'b1, 32'hC0FFEE11);

    // Reset in the middle of a load: aborted, array preserved.
    @(negedge cpu_clk);
    drive(4'hF, 4'h0, 32'h10, 32'h0);
    @(negedge cpu_clk);
    check_val("t6 busy before rst", 32'(bus.busy), 32'd1);
    cpu_rstn = 1'b0;
    idle();
    #1;
    check_quiet("t6 in reset");
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge cpu_clk);
      if (bus.daccess_valid || bus.daccess_wresp) pulses++;
    end
    check_val("t6 no pulse", 32'(pulses), 32'd0);
    check_quiet("t6 after reset");
    xact("t6 ld", 4'hF, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);

    check_val("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
